wptr_full: RTL and testbench

Write-side pointer and full-flag generator for the dual-clock asynchronous FIFO, running entirely in the write clock domain. It counts accepted writes, presents a binary RAM write address and a registered Gray-coded write pointer for the read domain, and synchronizes the read domain's Gray pointer to produce full, almost-full, occupancy and overflow status. It pairs with the read-pointer/empty block on the opposite side of the FIFO RAM.

---
 rtl/wptr_full_if.sv | 32 +++
 rtl/wptr_full.sv | 117 +++++++++++
 tb/tb_wptr_full.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/wptr_full_if.sv
// wptr_full_if
//   Bundles the write-side FIFO control signals between the write-domain
//   client and the wptr_full pointer/full-flag block.
//   master : client side  (drives winc, rptr_async, ovf_clr; sees status)
//   slave  : wptr_full    (consumes requests; drives wen, waddr, wptr,
//                          full, almost_full, wcount, overflow)
// Parameters
//   ADDR_WIDTH : RAM address bits; pointers are ADDR_WIDTH+1 bits wide
interface wptr_full_if #(
  parameter int ADDR_WIDTH = 4
);
  logic                  winc;
  logic [ADDR_WIDTH:0]   rptr_async;
  logic                  ovf_clr;
  logic                  wen;
  logic [ADDR_WIDTH-1:0] waddr;
  logic [ADDR_WIDTH:0]   wptr;
  logic                  full;
  logic                  almost_full;
  logic [ADDR_WIDTH:0]   wcount;
  logic                  overflow;

  modport master (
    output winc, rptr_async, ovf_clr,
    input  wen, waddr, wptr, full, almost_full, wcount, overflow
  );

  modport slave (
    input  winc, rptr_async, ovf_clr,
    output wen, waddr, wptr, full, almost_full, wcount, overflow
  );
endinterface

// File: rtl/wptr_full.sv
// wptr_full
//   Write-side pointer and full-flag generator of a dual-clock FIFO. Runs
//   entirely in the wclk domain: counts accepted writes, provides the binary
//   RAM write address and a registered Gray write pointer for the read
//   domain, and synchronizes the read-domain Gray pointer to derive full,
//   almost_full, occupancy and overflow status.
// Ports
//   wclk   : write clock (posedge)
//   w_nrst : asynchronous active-low reset
//   ifc    : wptr_full_if.slave
//            winc in, rptr_async in (Gray, async), ovf_clr in,
//            wen out (comb), waddr out, wptr out (Gray, registered),
//            full / almost_full / wcount / overflow out (registered)
// Parameters
//   ADDR_WIDTH : RAM address bits (>= 2), DEPTH = 2**ADDR_WIDTH
//   AF_MARGIN  : almost_full when free slots <= AF_MARGIN (1..DEPTH-1)
// Build option
//   WPTR_OVERFLOW_EN : when defined, a sticky overflow flag records writes
//                      attempted while full (cleared by ovf_clr). When not
//                      defined, overflow is tied to 0 and ovf_clr is ignored.
module wptr_full #(
  parameter int ADDR_WIDTH = 4,
  parameter int AF_MARGIN  = 2
) (
  input logic        wclk,
  input logic        w_nrst,
  wptr_full_if.slave ifc
);
  localparam int PTR_W = ADDR_WIDTH + 1;
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [PTR_W-1:0] AF_LEVEL = PTR_W'(DEPTH - AF_MARGIN);
  // Full when the write pointer is one lap ahead: in Gray code that means
  // the two MSBs differ and all lower bits match.
  localparam logic [PTR_W-1:0] FULL_MASK = PTR_W'(3) << (ADDR_WIDTH - 1);

  function automatic logic [PTR_W-1:0] gray2bin(input logic [PTR_W-1:0] g);
    logic [PTR_W-1:0] b;
    b[PTR_W-1] = g[PTR_W-1];
    for (int i = PTR_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  logic [PTR_W-1:0] wbin_q, wbin_d;
  logic [PTR_W-1:0] wptr_q, wptr_d;
  logic [PTR_W-1:0] rq1_q, rq1_d;
  logic [PTR_W-1:0] rq2_q, rq2_d;
  logic [PTR_W-1:0] wcount_q, wcount_d;
  logic             full_q, full_d;
  logic             almost_full_q, almost_full_d;
  logic [PTR_W-1:0] rbin_sync;
  logic             wen_c;

  always_comb begin
    wen_c         = ifc.winc & ~full_q;
    wbin_d        = wbin_q + {{ADDR_WIDTH{1'b0}}, wen_c};
    wptr_d        = wbin_d ^ (wbin_d >> 1);
    rq1_d         = ifc.rptr_async;
    rq2_d         = rq1_q;
    rbin_sync     = gray2bin(rq2_q);
    full_d        = (wptr_d == (rq2_q ^ FULL_MASK));
    wcount_d      = wbin_d - rbin_sync;
    almost_full_d = (wcount_d >= AF_LEVEL);
  end

  always_ff @(posedge wclk or negedge w_nrst) begin
    if (!w_nrst) begin
      wbin_q        <= '0;
      wptr_q        <= '0;
      rq1_q         <= '0;
      rq2_q         <= '0;
      wcount_q      <= '0;
      full_q        <= 1'b0;
      almost_full_q <= 1'b0;
    end else begin
      wbin_q        <= wbin_d;
      wptr_q        <= wptr_d;
      rq1_q         <= rq1_d;
      rq2_q         <= rq2_d;
      wcount_q      <= wcount_d;
      full_q        <= full_d;
      almost_full_q <= almost_full_d;
    end
  end

  assign ifc.wen         = wen_c;
  assign ifc.waddr       = wbin_q[ADDR_WIDTH-1:0];
  assign ifc.wptr        = wptr_q;
  assign ifc.full        = full_q;
  assign ifc.almost_full = almost_full_q;
  assign ifc.wcount      = wcount_q;

`ifdef WPTR_OVERFLOW_EN
  logic overflow_q, overflow_d;

  // A new overflow in the same cycle as ovf_clr keeps the flag set.
  always_comb begin
    overflow_d = (ifc.winc & full_q) | (overflow_q & ~ifc.ovf_clr);
  end

  always_ff @(posedge wclk or negedge w_nrst) begin
    if (!w_nrst) begin
      overflow_q <= 1'b0;
    end else begin
      overflow_q <= overflow_d;
    end
  end

  assign ifc.overflow = overflow_q;
`else
  logic unused_ovf_clr;
  assign unused_ovf_clr = ifc.ovf_clr;
  assign ifc.overflow   = 1'b0;
`endif

endmodule

// File: tb/tb_wptr_full.sv
// tb_wptr_full
//   Directed bench for wptr_full with ADDR_WIDTH=2, AF_MARGIN=2 (DEPTH=4).
//   Expected register values are queued before each clock step and popped
//   and compared one cycle later. Overflow expectations follow the
//   WPTR_OVERFLOW_EN build option.
module tb_wptr_full;
  localparam int AW = 2;

  typedef struct {
    string      tag;
    logic [1:0] waddr;
    logic [2:0] wptr;
    logic       full;
    logic       af;
    logic [2:0] wcount;
    logic       ovf;
  } exp_t;

  logic wclk   = 1'b0;
  logic w_nrst = 1'b0;

  wptr_full_if #(.ADDR_WIDTH(AW)) ifc ();

  wptr_full #(.ADDR_WIDTH(AW), .AF_MARGIN(2)) dut (
    .wclk   (wclk),
    .w_nrst (w_nrst),
    .ifc    (ifc)
  );

  always #5 wclk = ~wclk;

  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t exp_q[$];

  function automatic logic [2:0] gray(input int b);
    logic [2:0] x;
    x = 3'(b);
    return x ^ (x >> 1);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input string tag, input int waddr, input int wptr, input int full,
                      input int af, input int wcount, input int ovf);
    exp_t e;
    e.tag    = tag;
    e.waddr  = 2'(waddr);
    e.wptr   = 3'(wptr);
    e.full   = 1'(full);
    e.af     = 1'(af);
    e.wcount = 3'(wcount);
`ifdef WPTR_OVERFLOW_EN
    e.ovf    = 1'(ovf);
`else
    e.ovf    = 1'b0 & 1'(ovf);
`endif
    exp_q.push_back(e);
  endtask

  task automatic check_outputs();
    exp_t e;
    if (exp_q.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL scoreboard_empty observed=0 entries expected=1 entry");
    end else begin
      e = exp_q.pop_front();
      chk({e.tag, "_waddr"},  32'(ifc.waddr),       32'(e.waddr));
      chk({e.tag, "_wptr"},   32'(ifc.wptr),        32'(e.wptr));
      chk({e.tag, "_full"},   32'(ifc.full),        32'(e.full));
      chk({e.tag, "_af"},     32'(ifc.almost_full), 32'(e.af));
      chk({e.tag, "_wcount"}, 32'(ifc.wcount),      32'(e.wcount));
      chk({e.tag, "_ovf"},    32'(ifc.overflow),    32'(e.ovf));
    end
  endtask

  // Drive inputs mid-cycle, check combinational wen, clock once, compare.
  task automatic cycle(input string tag, input logic winc, input logic clr, input logic exp_wen);
    ifc.winc    = winc;
    ifc.ovf_clr = clr;
    #1;
    chk({tag, "_wen"}, 32'(ifc.wen), 32'(exp_wen));
    @(posedge wclk);
    #1;
    check_outputs();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [2:0] prev_wptr;
    ifc.winc       = 1'b0;
    ifc.ovf_clr    = 1'b0;
    ifc.rptr_async = '0;

    // Reset state
    #12;
    push("reset", 0, 0, 0, 0, 0, 0);
    check_outputs();
    chk("reset_wen", 32'(ifc.wen), 32'd0);
    w_nrst = 1'b1;
    @(posedge wclk);
    #1;

    // Fill the FIFO with the read pointer at 0
    push("w1", 1, 3'b001, 0, 0, 1, 0); cycle("w1", 1'b1, 1'b0, 1'b1);
    push("w2", 2, 3'b011, 0, 1, 2, 0); cycle("w2", 1'b1, 1'b0, 1'b1);
    push("w3", 3, 3'b010, 0, 1, 3, 0); cycle("w3", 1'b1, 1'b0, 1'b1);
    push("w4", 0, 3'b110, 1, 1, 4, 0); cycle("w4", 1'b1, 1'b0, 1'b1);

    // Write while full, overflow set / clear (set wins over clear)
    push("w5_full",  0, 3'b110, 1, 1, 4, 1); cycle("w5_full",  1'b1, 1'b0, 1'b0);
    push("set_wins", 0, 3'b110, 1, 1, 4, 1); cycle("set_wins", 1'b1, 1'b1, 1'b0);
    push("ovf_clr",  0, 3'b110, 1, 1, 4, 0); cycle("ovf_clr",  1'b0, 1'b1, 1'b0);

    // Read release: visible only on the 3rd edge after the change
    ifc.rptr_async = 3'b001;
    push("rel_e1", 0, 3'b110, 1, 1, 4, 0); cycle("rel_e1", 1'b0, 1'b0, 1'b0);
    push("rel_e2", 0, 3'b110, 1, 1, 4, 0); cycle("rel_e2", 1'b0, 1'b0, 1'b0);
    push("rel_e3", 0, 3'b110, 0, 1, 3, 0); cycle("rel_e3", 1'b0, 1'b0, 1'b0);

    // Refill, then hold winc while the read pointer advances
    push("w6", 1, 3'b111, 1, 1, 4, 0); cycle("w6", 1'b1, 1'b0, 1'b1);
    ifc.rptr_async = 3'b011;
    push("sim_e1", 1, 3'b111, 1, 1, 4, 1); cycle("sim_e1", 1'b1, 1'b0, 1'b0);
    push("sim_e2", 1, 3'b111, 1, 1, 4, 1); cycle("sim_e2", 1'b1, 1'b0, 1'b0);
    push("sim_e3", 1, 3'b111, 0, 1, 3, 1); cycle("sim_e3", 1'b1, 1'b0, 1'b0);
    push("sim_e4", 2, 3'b101, 1, 1, 4, 1); cycle("sim_e4", 1'b1, 1'b0, 1'b1);

    // Asynchronous reset while full, mid-cycle
    ifc.winc = 1'b1;
    #2;
    w_nrst = 1'b0;
    ifc.rptr_async = '0;
    #1;
    push("rst_async", 0, 0, 0, 0, 0, 0);
    check_outputs();
    chk("rst_async_wen", 32'(ifc.wen), 32'd1);
    @(posedge wclk);
    #1;
    push("rst_hold", 0, 0, 0, 0, 0, 0);
    check_outputs();
    #2;
    w_nrst = 1'b1;
    chk("post_rst_waddr0", 32'(ifc.waddr), 32'd0);
    push("post_rst_w", 1, 3'b001, 0, 0, 1, 0); cycle("post_rst_w", 1'b1, 1'b0, 1'b1);

    // Streaming with the read pointer trailing by one, wrapping wbin
    for (int n = 2; n <= 13; n++) begin
      prev_wptr = ifc.wptr;
      push("stream_w", n % 4, gray(n), 0, 1, 2, 0);
      cycle("stream_w", 1'b1, 1'b0, 1'b1);
      chk("stream_1bit", 32'($countones(ifc.wptr ^ prev_wptr)), 32'd1);
      ifc.rptr_async = gray(n - 1);
      push("stream_i1", n % 4, gray(n), 0, 1, 2, 0); cycle("stream_i1", 1'b0, 1'b0, 1'b0);
      push("stream_i2", n % 4, gray(n), 0, 1, 2, 0); cycle("stream_i2", 1'b0, 1'b0, 1'b0);
      push("stream_i3", n % 4, gray(n), 0, 0, 1, 0); cycle("stream_i3", 1'b0, 1'b0, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
